// File: rtl/prim_stream_unpack.sv
// Wide-to-narrow stream serialiser. It takes words from a FIFO read port and emits
// them as OutW-bit beats, least-significant beat first, with a per-word beat count.
module prim_stream_unpack #(
   parameter int   InW   = 32,
   parameter int   OutW  = 8,
   localparam int  Ratio = InW / OutW,
   localparam int  LenW  = $clog2(Ratio + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [InW-1:0]  in_data_i,
   input  logic [LenW-1:0] in_len_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [OutW-1:0] out_data_o,
   output logic            out_last_o,
   output logic            busy_o
);

   if (OutW <= 0 || InW <= 0 || (InW % OutW) != 0) begin : g_bad_width
      $error("prim_stream_unpack: InW must be a nonzero multiple of OutW");
   end

   typedef enum logic {
      Empty = 1'b0,
      Hold  = 1'b1
   } state_e;

   logic [InW-1:0]  hold_q, hold_d;
   logic [LenW-1:0] rem_q, rem_d;
   state_e          state;
   logic            fire_out;
   logic            fire_in;

   // Counts above Ratio would otherwise emit zero-filled beats beyond the word.
   function automatic logic [LenW-1:0] clamp_len(input logic [LenW-1:0] len);
      return (len > LenW'(Ratio)) ? LenW'(Ratio) : len;
   endfunction

   assign state       = (rem_q == '0) ? Empty : Hold;
   assign out_valid_o = (state == Hold);
   assign busy_o      = out_valid_o;
   assign out_data_o  = hold_q[OutW-1:0];
   assign out_last_o  = (rem_q == LenW'(1));

   assign fire_out   = out_valid_o & out_ready_i;
   assign in_ready_o = ~clr_i & ((state == Empty) | (fire_out & out_last_o));
   assign fire_in    = in_valid_i & in_ready_o;

   // A new word replaces whatever the final beat's shift would have left behind.
   always_comb begin
      hold_d = hold_q;
      rem_d  = rem_q;
      if (clr_i) begin
         hold_d = '0;
         rem_d  = '0;
      end else if (fire_in) begin
         hold_d = in_data_i;
         rem_d  = clamp_len(in_len_i);
      end else if (fire_out) begin
         hold_d = hold_q >> OutW;
         rem_d  = rem_q - LenW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q <= '0;
         rem_q  <= '0;
      end else begin
         hold_q <= hold_d;
         rem_q  <= rem_d;
      end
   end

endmodule
